// File: rtl/seg_disp_if.sv
// Bundle between the player control logic and the display arbiter:
// three level requesters in, one granted 4-digit value and enable out.
interface seg_disp_if;
  logic [2:0]  req;
  logic [15:0] req_data0;
  logic [15:0] req_data1;
  logic [15:0] req_data2;
  logic [2:0]  req_blink;
  logic [2:0]  gnt;
  logic [15:0] disp_data;
  logic        disp_en;
  logic        busy;

  modport master (
    output req, req_data0, req_data1, req_data2, req_blink,
    input  gnt, disp_data, disp_en, busy
  );

  modport slave (
    input  req, req_data0, req_data1, req_data2, req_blink,
    output gnt, disp_data, disp_en, busy
  );
endinterface

// File: rtl/seg_disp_arbiter.sv
// Round-robin sharing of the 4-digit 74HC595 display between three requesters,
// with a minimum dwell per grant and an optional per-requester blink.
module seg_disp_arbiter #(
  parameter int unsigned DWELL_CYC    = 25_000_000,
  parameter int unsigned BLINK_HALF   = 6_250_000,
  parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
  input logic       clk,
  input logic       rst,
  seg_disp_if.slave bus
);

  localparam int unsigned DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYC - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {IDLE, SHOW, LINGER} state_t;

  state_t        state, state_nx;
  logic [1:0]    last, last_nx;      // doubles as the granted index while busy
  logic [DW-1:0] dwell, dwell_nx;
  logic [BW-1:0] blink_cnt, blink_nx;
  logic [15:0]   data_q, data_nx;
  logic          en_q, en_nx;

  logic          g_req, others, expired, grant, to_idle;
  logic [1:0]    nxt;
  logic [2:0]    g_mask;
  logic [15:0]   sel_data;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // First asserted request after l in cyclic order, l itself checked last.
  function automatic logic [1:0] rr_next(input logic [1:0] l, input logic [2:0] r);
    logic [1:0] n1;
    logic [1:0] n2;
    n1 = inc3(l);
    n2 = inc3(n1);
    if (r[n1])      return n1;
    else if (r[n2]) return n2;
    else            return l;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 2'd2;
      dwell     <= '0;
      blink_cnt <= '0;
      data_q    <= IDLE_PATTERN;
      en_q      <= 1'b1;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      dwell     <= dwell_nx;
      blink_cnt <= blink_nx;
      data_q    <= data_nx;
      en_q      <= en_nx;
    end
  end

  always_comb begin
    g_mask = '0;
    g_mask[last] = 1'b1;
    unique case (last)
      2'd0:    sel_data = bus.req_data0;
      2'd1:    sel_data = bus.req_data1;
      default: sel_data = bus.req_data2;
    endcase
  end

  always_comb begin
    g_req    = bus.req[last];
    others   = |(bus.req & ~g_mask);
    expired  = (dwell == DWELL_MAX);
    nxt      = rr_next(last, bus.req);
    state_nx = state;
    last_nx  = last;
    dwell_nx = dwell;
    blink_nx = blink_cnt;
    data_nx  = data_q;
    en_nx    = en_q;
    grant    = 1'b0;
    to_idle  = 1'b0;

    if (state != IDLE) begin
      if (bus.req_blink[last]) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_nx = '0;
          en_nx    = ~en_q;
        end else begin
          blink_nx = blink_cnt + 1'b1;
        end
      end else begin
        blink_nx = '0;
        en_nx    = 1'b1;
      end
    end

    unique case (state)
      IDLE: grant = |bus.req;
      SHOW: begin
        if (g_req) data_nx = sel_data;
        if (expired) begin
          if (others)     grant    = 1'b1;
          else if (g_req) dwell_nx = '0;
          else            to_idle  = 1'b1;
        end else begin
          dwell_nx = dwell + 1'b1;
          if (!g_req) state_nx = LINGER;
        end
      end
      LINGER: begin
        // Expiry takes precedence over a re-assert: treated as released.
        if (expired) begin
          if (others) grant   = 1'b1;
          else        to_idle = 1'b1;
        end else begin
          dwell_nx = dwell + 1'b1;
          if (g_req) state_nx = SHOW;
        end
      end
      default: to_idle = 1'b1;
    endcase

    if (grant) begin
      state_nx = SHOW;
      last_nx  = nxt;
      dwell_nx = '0;
      blink_nx = '0;
      en_nx    = 1'b1;
    end else if (to_idle) begin
      state_nx = IDLE;
      dwell_nx = '0;
      blink_nx = '0;
      en_nx    = 1'b1;
      data_nx  = IDLE_PATTERN;
    end
  end

  always_comb begin
    bus.gnt = '0;
    if (state != IDLE) bus.gnt[last] = 1'b1;
    bus.busy      = (state != IDLE);
    bus.disp_data = data_q;
    bus.disp_en   = en_q;
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Scoreboard bench for seg_disp_arbiter with DWELL_CYC=8, BLINK_HALF=3:
// the driver queues hand-derived per-cycle outputs, a negedge monitor checks them.
module tb_seg_disp_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_disp_if bus ();

  seg_disp_arbiter #(
    .DWELL_CYC   (8),
    .BLINK_HALF  (3),
    .IDLE_PATTERN(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int unsigned cyc;
    logic [2:0]  gnt;
    logic [15:0] data;
    logic        en;
    logic        busy;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [2:0]  oh3 [3];
  logic [15:0] dv  [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp,
                     input int unsigned c);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk({e.tag, ".gnt"},  {13'b0, bus.gnt},     {13'b0, e.gnt},  e.cyc);
      chk({e.tag, ".data"}, bus.disp_data,        e.data,          e.cyc);
      chk({e.tag, ".en"},   {15'b0, bus.disp_en}, {15'b0, e.en},   e.cyc);
      chk({e.tag, ".busy"}, {15'b0, bus.busy},    {15'b0, e.busy}, e.cyc);
    end
  end

  // Apply inputs for the coming edge and queue the outputs expected after it.
  task automatic drive(input logic r_rst, input logic [2:0] r, input logic [2:0] b,
                       input logic [2:0] eg, input logic [15:0] ed, input logic ee,
                       input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r_rst;
    bus.req       = r;
    bus.req_blink = b;
    e.cyc  = cyc + 1;
    e.gnt  = eg;
    e.data = ed;
    e.en   = ee;
    e.busy = (eg != 3'b000);
    e.tag  = tag;
    sb.push_back(e);
  endtask

  initial begin
    oh3[0] = 3'b001; oh3[1] = 3'b010; oh3[2] = 3'b100;
    bus.req       = 3'b000;
    bus.req_blink = 3'b000;
    bus.req_data0 = 16'h1234;
    bus.req_data1 = 16'h2222;
    bus.req_data2 = 16'hABCD;

    repeat (2) drive(1'b1, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b1, "reset");
    for (int i = 0; i < 20; i++) drive(1'b0, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b1, "idle");

    // Single holder: grant held across dwell restarts, then linger to expiry.
    for (int i = 0; i < 20; i++)
      drive(1'b0, 3'b001, 3'b000, 3'b001, (i == 0) ? 16'h0000 : 16'h1234, 1'b1, "hold0");
    for (int i = 20; i < 24; i++)
      drive(1'b0, 3'b000, 3'b000, 3'b001, 16'h1234, 1'b1, "linger0");
    drive(1'b0, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b1, "release0");

    // Two requesters time-sliced every 8 cycles, no zero gap.
    drive(1'b1, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b1, "reset_c");
    bus.req_data0 = 16'h1111;
    dv[0] = 16'h1111; dv[1] = 16'h2222; dv[2] = 16'h3333;
    for (int i = 0; i < 32; i++)
      drive(1'b0, 3'b011, 3'b000, oh3[(i / 8) % 2],
            (i == 0) ? 16'h0000 : dv[((i - 1) / 8) % 2], 1'b1, "rr01");

    // Short pulse on requester 2: full dwell, frozen data, then idle.
    drive(1'b1, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b1, "reset_d");
    bus.req_data2 = 16'hABCD;
    for (int i = 0; i < 2; i++)
      drive(1'b0, 3'b100, 3'b000, 3'b100, (i == 0) ? 16'h0000 : 16'hABCD, 1'b1, "pulse2");
    for (int i = 2; i < 8; i++)
      drive(1'b0, 3'b000, 3'b000, 3'b100, 16'hABCD, 1'b1, "linger2");
    repeat (2) drive(1'b0, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b1, "idle2");

    // Blink on requester 0 (pointer still at 2 so 0 wins), continuing through linger.
    bus.req_data0 = 16'h5A5A;
    for (int i = 0; i < 20; i++)
      drive(1'b0, 3'b001, 3'b001, 3'b001, (i == 0) ? 16'h0000 : 16'h5A5A,
            ((i / 3) % 2) == 0, "blink0");
    for (int i = 20; i < 24; i++)
      drive(1'b0, 3'b000, 3'b001, 3'b001, 16'h5A5A, ((i / 3) % 2) == 0, "blink_linger");
    drive(1'b0, 3'b000, 3'b001, 3'b000, 16'h0000, 1'b1, "blink_idle");
    drive(1'b0, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b1, "idle3");

    // All three requesting; reset mid-grant of requester 1, then full rotation.
    drive(1'b1, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b1, "reset_f");
    bus.req_data0 = 16'h1111;
    bus.req_data1 = 16'h2222;
    bus.req_data2 = 16'h3333;
    for (int i = 0; i < 10; i++)
      drive(1'b0, 3'b111, 3'b000, (i < 8) ? 3'b001 : 3'b010,
            (i == 0) ? 16'h0000 : ((i <= 8) ? 16'h1111 : 16'h2222), 1'b1, "rr012");
    drive(1'b1, 3'b111, 3'b000, 3'b000, 16'h0000, 1'b1, "mid_reset");
    for (int j = 0; j < 24; j++)
      drive(1'b0, 3'b111, 3'b000, oh3[j / 8],
            (j == 0) ? 16'h0000 : dv[(j - 1) / 8], 1'b1, "rr012_after");

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_disp_arbiter.md
Name: seg_disp_arbiter

Overview:
- Shares the single 4-digit 74HC595 seven-segment display between three requesters, e.g. note/pitch readout, play timer and status code.
- Grants the display round-robin with a minimum dwell time per grant.
- Registers the granted 16-bit hex value onto the display driver's idis_data input and generates its en input, including an optional blink.
- Sits between the music-player control logic and the display driver module.

Parameters:
- DWELL_CYC, 25_000_000: minimum cycles a grant is held (1 s at 25 MHz); must be >= 2.
- BLINK_HALF, 6_250_000: half-period of blink in cycles; must be >= 1.
- IDLE_PATTERN, 16'h0000: value shown when no grant is active.

Ports:
- clk  in  1  system clock, 25 MHz
- rst  in  1  synchronous reset, active-high
- req  in  3  request per requester; level, held while display is wanted
- req_data0  in  16  4 hex digits from requester 0
- req_data1  in  16  4 hex digits from requester 1
- req_data2  in  16  4 hex digits from requester 2
- req_blink  in  3  per-requester blink enable; sampled while granted
- gnt  out  3  one-hot grant; all-zero when idle
- disp_data  out  16  to driver idis_data
- disp_en  out  1  to driver en; 1 = display running
- busy  out  1  1 when state is not IDLE

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state updates on posedge clk.
- Reset values:
  - state = IDLE
  - gnt = 3'b000
  - disp_data = IDLE_PATTERN
  - disp_en = 1
  - busy = 0
  - dwell counter = 0
  - blink counter = 0
  - round-robin pointer last = 2, so requester 0 wins first
- Rst asserted in any state returns everything to the reset values on the next edge. No grant survives reset.
- Arbitration function next(last): the first asserted req in the order last+1, last+2, last (mod 3).
- States:
  - IDLE: gnt = 0, disp_data = IDLE_PATTERN, disp_en = 1.
    - If any req: go to SHOW.
    - gnt <= onehot(next(last)); last <= next(last); dwell <= 0; blink counter <= 0; disp_en <= 1.
  - SHOW: granted requester g.
    - Each cycle, disp_data <= req_data[g]. One-cycle latency from req_data to disp_data.
    - dwell increments, saturating at DWELL_CYC-1.
    - If req[g] = 0 and dwell < DWELL_CYC-1: go to LINGER. disp_data freezes at its last value.
    - If dwell = DWELL_CYC-1 and req[g] = 0: go to IDLE if no other req; otherwise switch directly to next(last), same actions as the IDLE grant.
    - If dwell = DWELL_CYC-1, req[g] = 1 and another req is asserted: switch to next(last) (time-slice preemption). gnt changes in one cycle with no all-zero gap.
    - If dwell = DWELL_CYC-1, req[g] = 1 and no other req: stay; dwell restarts at 0.
  - LINGER: gnt stays asserted, disp_data frozen, dwell keeps counting.
    - If req[g] re-asserts: return to SHOW; dwell is not reset.
    - At dwell = DWELL_CYC-1: behave as SHOW with req[g] = 0.
- Blink:
  - In SHOW/LINGER with req_blink[g] = 1, the blink counter counts 0..BLINK_HALF-1. disp_en toggles when the counter wraps.
  - With req_blink[g] = 0, disp_en = 1 and the blink counter = 0.
  - Every new grant starts with disp_en = 1.
- Simultaneous events: a req rising in the same cycle as dwell expiry counts as pending. Requesters other than g are never granted mid-dwell.
- busy = (state != IDLE).
- gnt is always one-hot or zero.

Test Plan:
Use DWELL_CYC = 8, BLINK_HALF = 3 for all scenarios.
- Reset, then rst = 0 with req = 0: gnt = 000, disp_data = 16'h0000, disp_en = 1, busy = 0 for 20 cycles.
- req = 001, req_data0 = 16'h1234 held: gnt = 001 one cycle after req. disp_data = 16'h1234 one cycle later. Grant is held indefinitely and dwell restarts every 8 cycles.
- req = 011 from the same cycle: gnt = 001 for 8 cycles, then 010 for 8 cycles, alternating. disp_data tracks req_data0/req_data1 accordingly, with no 000 gap.
- req = 100 pulsed for 2 cycles with req_data2 = 16'hABCD: gnt = 100 for 8 cycles total, disp_data frozen at 16'hABCD, then IDLE with disp_data = 16'h0000.
- req = 001 with req_blink = 001: disp_en pattern 1,1,1,0,0,0,1... (period 6 cycles) while granted. disp_en = 1 immediately after IDLE re-entry.
- rst pulsed for 1 cycle mid-SHOW of requester 1 with req = 111: all outputs return to reset values; the next grant after release is 001.
